lane_avg_accum: RTL and testbench
=================================

# lane_avg_accum

Receive-side frame averager for the 8-lane sample stream. It accepts 32 beats of eight 8-bit samples (256 samples per frame) over a valid/ready handshake and sums each beat through a 3-stage pipelined pairwise tree. It accumulates the frame total and presents the 16-bit sum and the rounded 8-bit average through an output valid/ready handshake. It is the consumer end of the lane feeders that shift preloaded sample banks out one beat per cycle.

## Interface
- LANES, 8: samples per beat. Fixed at 8; the tree depth is 3.
- BEATS, 32: beats per frame. Must be a power of two.
- DW, 8: sample width.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  beat on in0..in7 is valid.
- in_ready  out  1  block accepts a beat this cycle.
- in0..in7  in  DW each  lane samples, unsigned.
- out_valid  out  1  sum/avg hold a completed frame result.
- out_ready  in  1  downstream takes the result.
- sum  out  16  frame total, unsigned.
- avg  out  8  rounded frame average.

## Operation
- A beat is accepted on a rising edge where in_valid && in_ready. Lane values are ignored when the beat is not accepted.
- Tree widths:
  - stage1: 4 sums of 9 bits.
  - stage2: 2 sums of 10 bits.
  - stage3: 1 sum of 11 bits.
  - accumulator: 16 bits. Max total is 256*255 = 65280, so there is no overflow.
- avg = (total + 128) >> 8, computed in 17 bits and truncated to 8. The maximum is 255, so the truncation is lossless.
- Each pipeline stage carries a valid bit. The accumulator adds stage3 only when stage3 is valid. Bubbles from in_valid gaps never add to the total.
- FSM, 3 states:
  - ACCUM: in_ready=1, count beats 0..31. Accepting beat 31 moves to DRAIN and drops in_ready from the next cycle.
  - DRAIN: in_ready=0. Wait until the pipeline is empty and the last beat is in the accumulator. Then load the sum/avg registers, set out_valid=1, and go to HOLD.
  - HOLD: in_ready=0. sum, avg and out_valid stay stable until out_valid && out_ready at an edge. On that edge: out_valid=0, accumulator and beat counter cleared, go to ACCUM, in_ready=1 from the next cycle.
- out_ready is ignored while out_valid=0.
- No partial-frame output, no frame abort other than rst.

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0, avg=0, state=ACCUM, beat count=0, all pipeline valids=0, accumulator=0.
- Reset mid-frame or mid-pipeline discards everything, including a held, unconsumed result.
- Per-beat latency: a beat accepted at edge E is in stage1 at E, stage2 at E+1, stage3 at E+2, and in the accumulator at E+3.
- Frame latency: if the last beat is accepted at edge E, out_valid=1 and sum/avg are valid after edge E+4.
- in_ready is low from the cycle after edge E, so it is never high in the same cycle as out_valid.
- Minimum frame period with continuous in_valid and out_ready tied high: 32 accept cycles + 4 drain + 1 handshake = 37 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs, including in_ready.

## Structure
- Shared package avg_pkg holds:
  - LANES, BEATS, DW.
  - SUM_W = DW + $clog2(LANES*BEATS) = 16.
  - ROUND = 1 << (SUM_W - DW - 1 + 1) >> 1, i.e. 128.
  - The FSM state enum {ACCUM, DRAIN, HOLD}.
- One natural sub-module, lane_sum_pipe:
  - The 3-stage valid-tagged pairwise tree.
  - Inputs: clk, rst, valid, 8 lanes.
  - Outputs: 11-bit sum and valid, latency 3.
- FSM, counter, accumulator and output registers live in the top module.

## Test plan
- **All-ones frame.** Every lane = 1 for 32 back-to-back beats, out_ready=1 → sum=256, avg=1. out_valid rises exactly 4 cycles after the 32nd accept.
- **Full-scale frame.** Every lane = 255 → sum=65280, avg=255. Check that nothing wraps at any tree stage.
- **Rounding boundary.**
  - One sample = 128, all others 0 → sum=128, avg=1.
  - Repeat with 127 → sum=127, avg=0.
  - Lanes = 0..7 every beat → sum=896, avg=4.
- **Backpressure.**
  - Random in_valid gaps, with lane values on non-accepted cycles set to 0xFF → the result equals the sum of accepted beats only.
  - Hold out_ready=0 for 10 cycles after out_valid → sum/avg are stable, in_ready=0, and no beats are accepted.
- **Back-to-back frames.** Two frames with constant lanes 10 then 20, out_ready=1 → results 2560/avg 10, then 5120/avg 20. The second frame starts accepting the cycle after the first handshake, and the period is 37 cycles.
- **Reset mid-operation.**
  - Assert rst after beat 17 → in_ready=1, out_valid=0 next cycle. A fresh full frame of all-2 yields sum=512, avg=2.
  - Assert rst during HOLD → the held result is dropped.

Source files
------------

// File: rtl/avg_pkg.sv
// Shared widths, FSM state type and rounding helper for the lane frame averager.
package avg_pkg;

  localparam int unsigned LANES = 8;
  localparam int unsigned BEATS = 32;
  localparam int unsigned DW    = 8;

  localparam int unsigned SUM_W = DW + $clog2(LANES * BEATS);
  localparam int unsigned ROUND = (1 << (SUM_W - DW - 1 + 1)) >> 1;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned AVG_W = SUM_W + 1;

  // Pairwise tree stage widths: one extra bit per level.
  localparam int unsigned S1_W = DW + 1;
  localparam int unsigned S2_W = DW + 2;
  localparam int unsigned S3_W = DW + 3;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // One beat of lane samples, lane 0 in the least significant byte.
  typedef logic [LANES-1:0][DW-1:0] beat_t;

  // Rounded average of a full frame: (total + ROUND) >> log2(LANES*BEATS).
  function automatic logic [DW-1:0] round_avg(input logic [SUM_W-1:0] total);
    logic [AVG_W-1:0] biased;
    biased = AVG_W'(total) + AVG_W'(ROUND);
    return DW'(biased >> (SUM_W - DW));
  endfunction

endpackage

// File: rtl/lane_avg_accum_if.sv
// Beat input and frame result handshakes of the lane frame averager.
interface lane_avg_accum_if;
  import avg_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in0;
  logic [DW-1:0]     in1;
  logic [DW-1:0]     in2;
  logic [DW-1:0]     in3;
  logic [DW-1:0]     in4;
  logic [DW-1:0]     in5;
  logic [DW-1:0]     in6;
  logic [DW-1:0]     in7;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  sum;
  logic [DW-1:0]     avg;

  // Producer of beats and consumer of results.
  modport master (
    output in_valid, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
    input  in_ready, out_valid, sum, avg
  );

  // The averager itself.
  modport slave (
    input  in_valid, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
    output in_ready, out_valid, sum, avg
  );

endinterface

// File: rtl/lane_sum_pipe.sv
// Three-stage valid-tagged pairwise adder tree: sums one beat of lanes, latency 3.
module lane_sum_pipe
  import avg_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  beat_t           lanes_i,
  output logic [S3_W-1:0] sum_o,
  output logic            valid_o,
  output logic            busy_c
);

  logic [LANES/2-1:0][S1_W-1:0] s1_d, s1_q;
  logic [LANES/4-1:0][S2_W-1:0] s2_d, s2_q;
  logic [S3_W-1:0]              s3_d, s3_q;
  logic                         v1_d, v1_q;
  logic                         v2_d, v2_q;
  logic                         v3_d, v3_q;

  // Next-stage sums; each level widens by one bit so nothing can wrap.
  always_comb begin
    s1_d = '0;
    s2_d = '0;
    s3_d = '0;
    for (int unsigned i = 0; i < LANES / 2; i++) begin
      s1_d[i] = S1_W'(lanes_i[2*i]) + S1_W'(lanes_i[2*i+1]);
    end
    for (int unsigned i = 0; i < LANES / 4; i++) begin
      s2_d[i] = S2_W'(s1_q[2*i]) + S2_W'(s1_q[2*i+1]);
    end
    s3_d = S3_W'(s2_q[0]) + S3_W'(s2_q[1]);
    v1_d = valid_i;
    v2_d = v1_q;
    v3_d = v2_q;
  end

  // Stage registers; valid bits travel alongside the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
    end
  end

  assign sum_o   = s3_q;
  assign valid_o = v3_q;
  assign busy_c  = v1_q | v2_q | v3_q;

endmodule

// File: rtl/lane_avg_accum.sv
// Frame averager: accumulates BEATS beats of LANES samples, then offers sum and rounded average.
module lane_avg_accum
  import avg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  lane_avg_accum_if.slave  bus
);

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  beat_cnt_d, beat_cnt_q;
  logic [SUM_W-1:0]  acc_d, acc_q;
  logic [SUM_W-1:0]  sum_d, sum_q;
  logic [DW-1:0]     avg_d, avg_q;
  logic              out_valid_d, out_valid_q;
  logic              in_ready_d, in_ready_q;

  beat_t             lanes_c;
  logic              accept_c;
  logic [S3_W-1:0]   pipe_sum;
  logic              pipe_valid;
  logic              pipe_busy_c;

  assign lanes_c  = {bus.in7, bus.in6, bus.in5, bus.in4,
                     bus.in3, bus.in2, bus.in1, bus.in0};
  assign accept_c = bus.in_valid && in_ready_q;

  lane_sum_pipe u_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (accept_c),
    .lanes_i (lanes_c),
    .sum_o   (pipe_sum),
    .valid_o (pipe_valid),
    .busy_c  (pipe_busy_c)
  );

  // Frame sequencing, accumulation and result loading.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    avg_d       = avg_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    if (pipe_valid) begin
      acc_d = acc_q + SUM_W'(pipe_sum);
    end

    unique case (state_q)
      ACCUM: begin
        if (accept_c) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
            state_d    = DRAIN;
            in_ready_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        // Pipeline empty means the last beat has already landed in acc_q.
        if (!pipe_busy_c) begin
          sum_d       = acc_q;
          avg_d       = round_avg(acc_q);
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          beat_cnt_d  = '0;
          in_ready_d  = 1'b1;
          state_d     = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and output registers; reset drops any frame in progress or held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      beat_cnt_q  <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      avg_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      avg_q       <= avg_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.avg       = avg_q;

endmodule

// File: tb/tb_lane_avg_accum.sv
// Self-checking bench for lane_avg_accum: directed frame table, random gapped frames, reset cases.
module tb_lane_avg_accum;
  import avg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lane_avg_accum_if bus_if ();

  lane_avg_accum dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  always @(posedge clk) edge_n++;

  // Reference model state: frame total is the plain sum of every accepted sample.
  int mdl_sum;
  int first_acc;
  int last_acc;
  int hs_edge;
  int got_sum;
  int got_avg;

  typedef struct {
    int    mode;      // 0: same beat every time, 1: pattern on first beat only, 2: random
    beat_t pat;
    int    exp_sum;
    int    exp_avg;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic set_lanes(input beat_t v);
    bus_if.in0 = v[0];
    bus_if.in1 = v[1];
    bus_if.in2 = v[2];
    bus_if.in3 = v[3];
    bus_if.in4 = v[4];
    bus_if.in5 = v[5];
    bus_if.in6 = v[6];
    bus_if.in7 = v[7];
  endtask

  // Offer beats until nbeats are accepted; gapped cycles carry 0xFF lanes with in_valid low.
  task automatic send_beats(input int mode, input beat_t pat, input int gap_pct, input int nbeats);
    int    got;
    int    guard;
    beat_t b;
    got   = 0;
    guard = 0;
    while (got < nbeats && guard < 1000) begin
      @(negedge clk);
      guard++;
      b = pat;
      if (mode == 1 && got != 0) b = '0;
      if (mode == 2) begin
        for (int l = 0; l < int'(LANES); l++) b[l] = DW'($urandom_range(255));
      end
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        bus_if.in_valid = 1'b0;
        set_lanes('1);
      end else begin
        bus_if.in_valid = 1'b1;
        set_lanes(b);
        if (bus_if.in_ready) begin
          if (got == 0) first_acc = edge_n + 1;
          last_acc = edge_n + 1;
          got++;
          for (int l = 0; l < int'(LANES); l++) mdl_sum += int'(b[l]);
        end
      end
    end
    if (got != nbeats) check("beat_accept_timeout", 32'(got), 32'(nbeats));
  endtask

  // Wait for the result, compare against the model, optionally stall, then handshake.
  task automatic wait_result(input int hold_cycles, input bit do_hs);
    int guard;
    int exp_avg;
    guard = 0;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    set_lanes('1);
    while (!bus_if.out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("result_valid", 32'(bus_if.out_valid), 32'd1);
    if (!bus_if.out_valid) return;
    exp_avg = (mdl_sum + 128) / 256;
    check("frame_latency", 32'(edge_n - last_acc), 32'd4);
    check("in_ready_low_at_result", 32'(bus_if.in_ready), 32'd0);
    check("sum_vs_model", 32'(bus_if.sum), 32'(mdl_sum));
    check("avg_vs_model", 32'(bus_if.avg), 32'(exp_avg));
    got_sum = int'(bus_if.sum);
    got_avg = int'(bus_if.avg);
    for (int k = 0; k < hold_cycles; k++) begin
      bus_if.out_ready = 1'b0;
      bus_if.in_valid  = 1'b1;
      set_lanes('1);
      @(negedge clk);
      check("hold_sum_stable", 32'(bus_if.sum), 32'(got_sum));
      check("hold_avg_stable", 32'(bus_if.avg), 32'(got_avg));
      check("hold_out_valid", 32'(bus_if.out_valid), 32'd1);
      check("hold_in_ready_low", 32'(bus_if.in_ready), 32'd0);
    end
    bus_if.in_valid = 1'b0;
    if (!do_hs) return;
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    hs_edge = edge_n;
    check("hs_out_valid_clear", 32'(bus_if.out_valid), 32'd0);
    check("hs_in_ready_set", 32'(bus_if.in_ready), 32'd1);
    bus_if.out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_if.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_sum", 32'(bus_if.sum), 32'd0);
    check("rst_avg", 32'(bus_if.avg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    beat_t p;
    int    prev_first;
    int    prev_hs;

    // Directed frame table with hand-derived results.
    tbl[0] = '{0, {8{8'd1}},   256,   1};
    tbl[1] = '{0, {8{8'd255}}, 65280, 255};
    p = '0; p[0] = 8'd128;
    tbl[2] = '{1, p,           128,   1};
    p = '0; p[0] = 8'd127;
    tbl[3] = '{1, p,           127,   0};
    for (int l = 0; l < int'(LANES); l++) p[l] = DW'(l);
    tbl[4] = '{0, p,           896,   4};
    tbl[5] = '{0, {8{8'd10}},  2560,  10};
    tbl[6] = '{0, {8{8'd20}},  5120,  20};

    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    set_lanes('0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(bus_if.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("reset_sum", 32'(bus_if.sum), 32'd0);
    check("reset_avg", 32'(bus_if.avg), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    prev_first = 0;
    prev_hs    = 0;
    for (int i = 0; i < 7; i++) begin
      mdl_sum = 0;
      send_beats(tbl[i].mode, tbl[i].pat, 0, int'(BEATS));
      if (i == 6) begin
        check("restart_after_handshake", 32'(first_acc - prev_hs), 32'd1);
        check("frame_period", 32'(first_acc - prev_first), 32'd37);
      end
      prev_first = first_acc;
      wait_result((i == 4) ? 10 : 0, 1'b1);
      prev_hs = hs_edge;
      check("tbl_sum", 32'(got_sum), 32'(tbl[i].exp_sum));
      check("tbl_avg", 32'(got_avg), 32'(tbl[i].exp_avg));
    end

    // Random lanes with random in_valid gaps and short output stalls.
    for (int f = 0; f < 4; f++) begin
      mdl_sum = 0;
      send_beats(2, '0, 30, int'(BEATS));
      wait_result(int'($urandom_range(3)), 1'b1);
    end

    // Reset after 17 beats, then a clean all-2 frame.
    mdl_sum = 0;
    send_beats(0, {8{8'd9}}, 0, 17);
    pulse_reset();
    mdl_sum = 0;
    send_beats(0, {8{8'd2}}, 0, int'(BEATS));
    wait_result(0, 1'b1);
    check("after_midframe_rst_sum", 32'(got_sum), 32'd512);
    check("after_midframe_rst_avg", 32'(got_avg), 32'd2);

    // Reset while a result is held: it must vanish and the next frame start from zero.
    mdl_sum = 0;
    send_beats(0, {8{8'd3}}, 0, int'(BEATS));
    wait_result(2, 1'b0);
    pulse_reset();
    mdl_sum = 0;
    send_beats(0, {8{8'd1}}, 0, int'(BEATS));
    wait_result(0, 1'b1);
    check("after_hold_rst_sum", 32'(got_sum), 32'd256);
    check("after_hold_rst_avg", 32'(got_avg), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
